// File: rtl/axis_endian_pkg.sv
// Shared types and keep/byte helpers for the AXI-Stream endianness restorer.
// Helpers work on the widest supported beat; callers pass the live byte count.
package axis_endian_pkg;

  localparam int unsigned MAX_BYTES = 64;
  localparam int unsigned MAX_BITS  = MAX_BYTES * 8;

  typedef enum logic [0:0] {
    IDLE,
    MID
  } pkt_state_t;

  // Byte i of the result takes byte n-1-i of d; bytes at or above n are zero.
  function automatic logic [MAX_BITS-1:0] byte_reverse(
    input logic [MAX_BITS-1:0] d,
    input int unsigned         n
  );
    logic [MAX_BITS-1:0] r;
    logic [5:0]          src;
    r   = '0;
    src = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n) begin
        src = 6'(n - 1 - i);
        r[{6'(i), 3'b000} +: 8] = d[{src, 3'b000} +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [MAX_BYTES-1:0] bit_reverse(
    input logic [MAX_BYTES-1:0] v,
    input int unsigned          n
  );
    logic [MAX_BYTES-1:0] r;
    logic [5:0]           src;
    r   = '0;
    src = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n) begin
        src       = 6'(n - 1 - i);
        r[6'(i)]  = v[src];
      end
    end
    return r;
  endfunction

  // Index of the lowest set bit; an all-zero vector reports 0.
  function automatic int unsigned trailing_zeros(
    input logic [MAX_BYTES-1:0] v,
    input int unsigned          n
  );
    int unsigned tz;
    logic        found;
    tz    = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n && v[6'(i)] && !found) begin
        tz    = i;
        found = 1'b1;
      end
    end
    return tz;
  endfunction

  // True when v holds exactly one run of ones (at any offset).
  function automatic logic is_contiguous(input logic [MAX_BYTES-1:0] v);
    logic [MAX_BYTES-1:0] x;
    x = v >> trailing_zeros(v, MAX_BYTES);
    return (v != '0) && ((x & (x + MAX_BYTES'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Registered ready/valid stage with one skid slot: full throughput, no
// combinational path between the two handshakes, order always preserved.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_payload,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_payload
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_payload;
  logic             s_fire;

  assign s_fire = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid    <= 1'b0;
      skid_valid <= 1'b0;
      s_ready    <= 1'b0;
    end else if (!m_valid || m_ready) begin
      // Output slot frees up: a held skid beat always goes first. s_ready is
      // low whenever the skid is full, so no new beat can arrive alongside it.
      if (skid_valid) begin
        m_valid    <= 1'b1;
        m_payload  <= skid_payload;
        skid_valid <= 1'b0;
      end else begin
        m_valid <= s_fire;
        if (s_fire) begin
          m_payload <= s_payload;
        end
      end
      s_ready <= 1'b1;
    end else if (s_fire) begin
      skid_valid   <= 1'b1;
      skid_payload <= s_payload;
      s_ready      <= 1'b0;
    end else begin
      s_ready <= !skid_valid;
    end
  end

endmodule

// File: rtl/axis_endianness_restorer.sv
// Receive-side AXI-Stream byte-order restorer with last-beat realignment and
// sticky keep checking. Define AXIS_ENDIAN_STATS_EN to add packet/error counters.
module axis_endianness_restorer
  import axis_endian_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic [DATA_WIDTH/8-1:0] s_strb,
  input  logic                    s_last,
  input  logic [DEST_WIDTH-1:0]   s_dest,
  input  logic [USER_WIDTH-1:0]   s_user,
  input  logic [ID_WIDTH-1:0]     s_id,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic [DATA_WIDTH/8-1:0] m_keep,
  output logic [DATA_WIDTH/8-1:0] m_strb,
  output logic                    m_last,
  output logic [DEST_WIDTH-1:0]   m_dest,
  output logic [USER_WIDTH-1:0]   m_user,
  output logic [ID_WIDTH-1:0]     m_id,
  output logic                    err_keep
`ifdef AXIS_ENDIAN_STATS_EN
  ,
  output logic [31:0]             pkt_count,
  output logic [15:0]             err_count
`endif
);

  localparam int unsigned N  = DATA_WIDTH / 8;
  localparam int unsigned PW = DATA_WIDTH + 2 * N + 1 + DEST_WIDTH + USER_WIDTH + ID_WIDTH;

  pkt_state_t state;

  logic [DATA_WIDTH-1:0] data_rev;
  logic [N-1:0]          keep_rev;
  logic [N-1:0]          strb_rev;
  int unsigned           keep_tz;
  logic                  keep_contig;
  logic                  tail_beat;
  logic                  realign;
  logic                  beat_bad;
  logic [DATA_WIDTH-1:0] proc_data;
  logic [N-1:0]          proc_keep;
  logic [N-1:0]          proc_strb;
  logic                  in_fire;
  logic [PW-1:0]         in_payload;
  logic [PW-1:0]         out_payload;

  assign in_fire = s_valid && s_ready;

  always_comb begin
    data_rev    = DATA_WIDTH'(byte_reverse(MAX_BITS'(s_data), N));
    keep_rev    = N'(bit_reverse(MAX_BYTES'(s_keep), N));
    strb_rev    = N'(bit_reverse(MAX_BYTES'(s_strb), N)) & keep_rev;
    keep_tz     = trailing_zeros(MAX_BYTES'(keep_rev), N);
    keep_contig = is_contiguous(MAX_BYTES'(keep_rev));
    // A last beat closes the packet from either state: a single-beat packet
    // arrives in IDLE, a multi-beat tail in MID.
    tail_beat   = s_last && (state == IDLE || state == MID);
    realign     = tail_beat && keep_contig && (keep_tz != 0);
    beat_bad    = (keep_rev == '0)
               || (!s_last && keep_rev != '1)
               || (s_last && !keep_contig);
    proc_data   = data_rev;
    proc_keep   = keep_rev;
    proc_strb   = strb_rev;
    if (realign) begin
      proc_data = data_rev >> (keep_tz * 8);
      proc_keep = keep_rev >> keep_tz;
      proc_strb = strb_rev >> keep_tz;
    end
  end

  assign in_payload = {proc_data, proc_keep, proc_strb, s_last, s_dest, s_user, s_id};

  axis_skid_buffer #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_payload(in_payload),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_payload(out_payload)
  );

  assign {m_data, m_keep, m_strb, m_last, m_dest, m_user, m_id} = out_payload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (in_fire) begin
      state <= s_last ? IDLE : MID;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_keep <= 1'b0;
    end else if (in_fire && beat_bad) begin
      err_keep <= 1'b1;
    end
  end

`ifdef AXIS_ENDIAN_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (m_valid && m_ready && m_last) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (in_fire && beat_bad && err_count != '1) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/axis_endianness_restorer.md
Name:
axis_endianness_restorer

Overview:
- Receive-side counterpart of the AXI-Stream byte-swap converter.
- Undoes the per-beat byte reversal on data, keep and strb.
- LSB-realigns partially-kept beats and checks keep legality per packet.
- Registered output with a skid buffer: full throughput, breaks combinational ready/valid paths between the link and the user core.

Parameters:
- DATA_WIDTH, 64, stream data width in bits; multiple of 8, 8..512; N = DATA_WIDTH/8 bytes.
- DEST_WIDTH, 1, tdest width; passed through unchanged.
- USER_WIDTH, 1, tuser width; passed through unchanged.
- ID_WIDTH, 1, tid width; passed through unchanged.

Ports:
- clk  in  1  stream clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when high with s_valid.
- s_data  in  DATA_WIDTH  byte-reversed data.
- s_keep  in  N  byte-reversed keep.
- s_strb  in  N  byte-reversed strobe.
- s_last  in  1  end of packet.
- s_dest / s_user / s_id  in  DEST_WIDTH / USER_WIDTH / ID_WIDTH  sideband.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  restored data.
- m_keep  out  N  restored keep.
- m_strb  out  N  restored strb.
- m_last  out  1  end of packet.
- m_dest / m_user / m_id  out  sideband widths  passed through.
- err_keep  out  1  sticky protocol-error flag.

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on rising clk.
  - m_valid=0, s_ready=0 during reset, s_ready=1 the cycle after rst deasserts, err_keep=0, FSM=IDLE, skid buffer empty.
  - Reset mid-packet discards any held beat with no output; the next accepted beat starts a new packet.
- Un-swap: byte i of the restored word = s_data byte N-1-i; same mapping for keep and strb bits.
- Realign, last beats only:
  - If restored keep is one contiguous run of ones starting at bit t>0, shift data, keep and strb right by t bytes; vacated high bytes are zero.
  - Non-last beats are never shifted.
- Keep checks (any failure sets err_keep):
  - Non-last beat with keep != all-ones.
  - Any beat with keep == 0.
  - Non-contiguous keep on a last beat. That beat passes through un-swapped but not shifted.
  - strb bits outside keep are forced to 0; this does not raise an error.
- FSM (tracks packet position):
  - States IDLE, MID.
  - IDLE: an accepted beat with s_last=0 goes to MID; with s_last=1 stays IDLE.
  - MID: an accepted beat with s_last=1 goes to IDLE.
  - The FSM only gates the realign rule; error detection is per beat.
- err_keep:
  - Sticky until rst.
  - Rises the cycle after the offending beat is accepted.
  - Does not block or drop traffic.
- Pipeline:
  - One output register plus one skid register.
  - Latency is 1 cycle from s_valid&&s_ready to m_valid.
  - s_ready = !skid_full (registered).
  - Back-to-back beats sustain 1 beat/clk while m_ready=1.
- Stall handling:
  - When m_ready drops, one in-flight beat lands in the skid register and s_ready falls the next cycle.
  - On m_ready return, the skid beat is presented first; order is always preserved.
- Output stability: while m_valid=1 and m_ready=0, all m_* outputs hold stable.
- Simultaneous events:
  - Accept and emit in the same cycle with skid empty: the output register reloads directly, and the skid stays empty.

Optional Feature:
- Macro: AXIS_ENDIAN_STATS_EN.
- When defined:
  - Adds outputs pkt_count[31:0] and err_count[15:0].
  - pkt_count increments on each emitted beat with m_valid&&m_ready&&m_last.
  - err_count increments once per offending accepted beat and saturates at 16'hFFFF.
  - pkt_count wraps at 2^32 to 0.
  - Both counters clear on rst.
- When undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package axis_endian_pkg holds:
  - FSM state enum (IDLE, MID).
  - Function for contiguous-run detection.
  - Function for trailing-zero count on the N-bit keep vector.
  - Byte-reverse function.
- One sub-module: axis_skid_buffer.
  - Parameterised payload width; carries the concatenated {data, keep, strb, last, dest, user, id}.
  - Reusable elsewhere in the stream IP set.

Test Plan:
- DATA_WIDTH=64: s_data=64'h0102030405060708, keep=8'hFF, last=1, m_ready=1 -> m_data=64'h0807060504030201, m_keep=8'hFF one cycle later, err_keep=0.
- Last beat with s_keep=8'b1110_0000 (three bytes, reversed) -> restored keep 8'b0000_0111, no shift, m_keep=8'h07; s_keep=8'b0000_1110 -> restored 8'b0111_0000, shifted down 4 bytes, m_keep=8'h07.
- Continuous stream of 100 beats with m_ready toggled pseudo-randomly:
  - No loss or duplication, order preserved.
  - Throughput 1 beat/clk whenever m_ready is held high.
  - m_* stable while stalled.
- Non-last beat with keep=8'h0F -> err_keep=1 next cycle and stays high; following packets pass unaffected; rst clears the flag.
- Assert rst mid-packet with the skid full -> m_valid=0 the following cycle, no stale beat emitted, next packet processed starting in IDLE.
- With AXIS_ENDIAN_STATS_EN: 5 packets, one containing a keep=0 beat -> pkt_count=5, err_count=1.
